clock_set_controller: RTL and testbench
=======================================

# clock_set_controller

Button-driven time-set sequencer for the 24-hour clock counter. It turns two raw push-buttons (mode, increment) into an edit session that walks hours → minutes → seconds. The session finishes by presenting a BCD HHMMSS word and a one-cycle load strobe to the clock counter's synchronous load input. It also drives field-select and blink-blank indications for the seven-segment display path.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 10000: consecutive stable cycles (10 ms at 1 MHz) before a button level is accepted.
- BLINK_HALF_CYCLES, 250000: half-period of the edit-field blink, in cycles.

Ports:
- clock_1MHz  in  1  system clock.
- reset  in  1  synchronous, active-high.
- btn_mode  in  1  raw mode button, asynchronous, active-high.
- btn_inc  in  1  raw increment button, asynchronous, active-high.
- cur_time  in  24  running time, BCD {hourTens, hourOnes, minTens, minOnes, secTens, secOnes}, 4 bits each.
- set_time  out  24  edited time, same BCD layout.
- load  out  1  one-cycle strobe; clock counter loads set_time.
- editing  out  1  high while any edit state is active.
- field_sel  out  2  0 = none, 1 = hours, 2 = minutes, 3 = seconds.
- blank  out  1  display blanks the selected field while high.

## Operation
- **Button conditioning.** Each button passes through a 2-flop synchronizer, then the debouncer, then a rising-edge detector. The result is a one-cycle press pulse (mode_p, inc_p).
- **State machine.** States are RUN, SET_HR, SET_MIN, SET_SEC, COMMIT.
  - RUN, mode_p: capture cur_time into the edit registers; go to SET_HR.
  - SET_HR, mode_p: go to SET_MIN. SET_MIN, mode_p: go to SET_SEC. SET_SEC, mode_p: go to COMMIT.
  - COMMIT: load = 1 for exactly this cycle; unconditionally go to RUN.
- **Increment (inc_p in an edit state).** BCD +1 on the selected field.
  - Hours wrap 23 → 00. Minutes and seconds wrap 59 → 00.
  - Ones digit carries into tens. The carry stays inside the field and never propagates to the next field.
  - A captured value that is not valid BCD or is out of range (e.g. hour 2_5, minute 6_3, digit > 9) becomes 00 on the next increment.
- **Ignored presses.** inc_p is ignored in RUN and COMMIT.
- **Simultaneous presses.** If mode_p and inc_p occur in the same cycle, mode wins and the increment is dropped.
- **set_time** continuously reflects the edit registers. It holds its value after COMMIT until the next capture.
- **editing** is 1 in SET_HR/SET_MIN/SET_SEC and 0 in RUN/COMMIT.
- **field_sel** is 1/2/3 in the three edit states and 0 otherwise.
- **Blink.**
  - The counter clears and blank = 0 on every edit-state entry and on every accepted inc_p, so the edited digit is immediately visible.
  - Otherwise blank toggles every BLINK_HALF_CYCLES cycles.
  - blank = 0 in RUN and COMMIT.

## Timing
- **Reset values** (reset overrides everything, including mid-edit; no commit occurs): state RUN, set_time 0, load 0, editing 0, field_sel 0, blank 0. Synchronizers, debouncers and edge detectors all clear to "released".
- **Press latency.** A raw level change stable from cycle 0 produces a press pulse at cycle 2 + DEBOUNCE_CYCLES + 1.
- **Debounce.** Any bounce during the window restarts the stable count. Release is debounced the same way, and only presses generate pulses.
- **State change.** mode_p in cycle N changes state at N+1. A capture initiated at N has the edit registers valid at N+1.
- **Commit.** mode_p in SET_SEC at N gives load = 1 at N+1 and state RUN at N+2.
- **Increment.** inc_p at N gives the updated set_time at N+1.

## Configuration
- **CLOCK_SET_DEBOUNCE_EN defined:** the debouncer is instantiated as described above.
- **CLOCK_SET_DEBOUNCE_EN undefined:** synchronizer outputs feed the edge detectors directly, DEBOUNCE_CYCLES is unused, and press latency is 3 cycles. This build is for simulation or for pre-debounced inputs.

## Structure
- **Shared package (clock_pkg):**
  - state enumeration;
  - field_sel encodings;
  - BCD limit constants (HOUR_MAX 23, MIN_SEC_MAX 59);
  - BCD field offsets within the 24-bit word.
- **Sub-module:** one, button_debouncer (synchronizer + stable counter + edge detect, parameterized by DEBOUNCE_CYCLES), instantiated twice.

## Test plan
Bench uses DEBOUNCE_CYCLES = 4 and BLINK_HALF_CYCLES = 8.
- **Full edit path.** cur_time = 12:34:56. Press mode, inc ×2 (hours), mode, inc (minutes), mode, mode. → one load pulse with set_time = 14:35:56; editing 0 and field_sel 0 afterwards.
- **Wrap.** Hours 23 + inc → 00. Minutes 59 + inc → 00, with the hour unchanged. Seconds 09 + inc → 10.
- **Debounce.** btn_inc toggling every 2 cycles for 20 cycles, then held high. → exactly one increment, 2 + 4 + 1 cycles after the final rising edge.
- **Simultaneous and ignored presses.** Mode and inc pressed in the same cycle in SET_MIN → state SET_SEC, minutes unchanged. inc in RUN → no change and no load.
- **Reset mid-edit.** Reset asserted in SET_MIN after two increments → no load pulse; all outputs 0 the next cycle.
- **Blink.** Enter SET_HR → blank 0 for 8 cycles then 1 for 8. An inc at cycle 12 → blank 0 at cycle 13 and the count restarts.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the time-set sequencer: FSM states, field-select
// codes, BCD limits, field offsets inside the HHMMSS word and the per-field
// BCD increment used by the editor.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_HR,
    SET_MIN,
    SET_SEC,
    COMMIT
  } setState_t;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HR   = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_SEC  = 2'd3
  } fieldSel_t;

  localparam logic [7:0] HOUR_MAX    = 8'h23;
  localparam logic [7:0] MIN_SEC_MAX = 8'h59;

  localparam int HOUR_OFS = 16;
  localparam int MIN_OFS  = 8;
  localparam int SEC_OFS  = 0;

  // Two-digit BCD +1 that wraps at maxV. Anything that is not a valid,
  // in-range BCD value restarts the field at 00. The carry never leaves
  // the field.
  function automatic logic [7:0] bcdInc(input logic [7:0] v, input logic [7:0] maxV);
    logic [7:0] r;
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v >= maxV) r = 8'h00;
    else if (v[3:0] == 4'd9)                         r = {v[7:4] + 4'd1, 4'h0};
    else                                             r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw push-button to one-cycle press pulse: 2-flop synchronizer, optional
// stable-level filter, rising-edge detector.
// Build option: CLOCK_SET_DEBOUNCE_EN enables the stable-level filter;
// without it the synchronizer output feeds the edge detector directly.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic clock_1MHz,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic syncA, syncB;
  logic stable, stablePrev;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clock_1MHz) begin
    if (reset) begin
      syncA <= 1'b0;
      syncB <= 1'b0;
    end else begin
      syncA <= btn;
      syncB <= syncA;
    end
  end

`ifdef CLOCK_SET_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] stableCnt;
  logic             level;

  // Accept a new level only after it has differed from the accepted one for
  // DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  always_ff @(posedge clock_1MHz) begin
    if (reset) begin
      level     <= 1'b0;
      stableCnt <= '0;
    end else if (syncB == level) begin
      stableCnt <= '0;
    end else if (stableCnt == CNT_LAST) begin
      level     <= syncB;
      stableCnt <= '0;
    end else begin
      stableCnt <= stableCnt + 1'b1;
    end
  end

  assign stable = level;
`else
  assign stable = syncB;
`endif

  // Pulse for one cycle on an accepted press; releases make no pulse.
  always_ff @(posedge clock_1MHz) begin
    if (reset) begin
      stablePrev <= 1'b0;
      press      <= 1'b0;
    end else begin
      stablePrev <= stable;
      press      <= stable & ~stablePrev;
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Button-driven time-set sequencer: RUN -> SET_HR -> SET_MIN -> SET_SEC ->
// COMMIT. Edits a captured copy of cur_time field by field and strobes load
// for one cycle so the clock counter takes set_time.
// Build option: CLOCK_SET_DEBOUNCE_EN enables button debouncing.
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 10000,
  parameter int BLINK_HALF_CYCLES = 250000
) (
  input  logic        clock_1MHz,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [23:0] cur_time,
  output logic [23:0] set_time,
  output logic        load,
  output logic        editing,
  output logic [1:0]  field_sel,
  output logic        blank
);

  localparam int BLINK_W = $clog2(BLINK_HALF_CYCLES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYCLES - 1);

  setState_t          state;
  logic               modeP, incP;
  logic [BLINK_W-1:0] blinkCnt;
  logic [7:0]         curField, fieldMax, incField;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uModeBtn (
    .clock_1MHz (clock_1MHz),
    .reset      (reset),
    .btn        (btn_mode),
    .press      (modeP)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uIncBtn (
    .clock_1MHz (clock_1MHz),
    .reset      (reset),
    .btn        (btn_inc),
    .press      (incP)
  );

  // Incremented value of whichever field the current state is editing.
  always_comb begin
    curField = set_time[SEC_OFS +: 8];
    fieldMax = MIN_SEC_MAX;
    case (state)
      SET_HR: begin
        curField = set_time[HOUR_OFS +: 8];
        fieldMax = HOUR_MAX;
      end
      SET_MIN: curField = set_time[MIN_OFS +: 8];
      default: ;
    endcase
    incField = bcdInc(curField, fieldMax);
  end

  // Edit sequencer with registered outputs; mode beats a same-cycle inc,
  // and every state entry or accepted inc restarts the blink visible.
  always_ff @(posedge clock_1MHz) begin
    if (reset) begin
      state     <= RUN;
      set_time  <= '0;
      load      <= 1'b0;
      editing   <= 1'b0;
      field_sel <= FIELD_NONE;
      blank     <= 1'b0;
      blinkCnt  <= '0;
    end else begin
      load <= 1'b0;
      unique case (state)
        RUN: begin
          if (modeP) begin
            set_time  <= cur_time;
            state     <= SET_HR;
            editing   <= 1'b1;
            field_sel <= FIELD_HR;
            blank     <= 1'b0;
            blinkCnt  <= '0;
          end
        end
        SET_HR, SET_MIN, SET_SEC: begin
          if (modeP) begin
            blank    <= 1'b0;
            blinkCnt <= '0;
            case (state)
              SET_HR: begin
                state     <= SET_MIN;
                field_sel <= FIELD_MIN;
              end
              SET_MIN: begin
                state     <= SET_SEC;
                field_sel <= FIELD_SEC;
              end
              default: begin
                state     <= COMMIT;
                editing   <= 1'b0;
                field_sel <= FIELD_NONE;
                load      <= 1'b1;
              end
            endcase
          end else if (incP) begin
            blank    <= 1'b0;
            blinkCnt <= '0;
            case (state)
              SET_HR:  set_time[HOUR_OFS +: 8] <= incField;
              SET_MIN: set_time[MIN_OFS +: 8]  <= incField;
              default: set_time[SEC_OFS +: 8]  <= incField;
            endcase
          end else if (blinkCnt == BLINK_LAST) begin
            blinkCnt <= '0;
            blank    <= ~blank;
          end else begin
            blinkCnt <= blinkCnt + 1'b1;
          end
        end
        COMMIT: state <= RUN;
        default: begin
          state     <= RUN;
          editing   <= 1'b0;
          field_sel <= FIELD_NONE;
          blank     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller with a cycle-level reference
// model built from the press/debounce/edit rules (integer fields, history
// of raw button samples, blink age in cycles).
module tb_clock_set_controller;

  localparam int D = 4;
  localparam int B = 8;
`ifdef CLOCK_SET_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
  localparam int LAT = D + 3;
`else
  localparam bit DEB = 1'b0;
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bm = 1'b0, bi = 1'b0;
  logic [23:0] ct = '0;
  logic [23:0] set_time;
  logic        load, editing, blank;
  logic [1:0]  field_sel;

  clock_set_controller #(.DEBOUNCE_CYCLES(D), .BLINK_HALF_CYCLES(B)) dut (
    .clock_1MHz (clk),
    .reset      (rst),
    .btn_mode   (bm),
    .btn_inc    (bi),
    .cur_time   (ct),
    .set_time   (set_time),
    .load       (load),
    .editing    (editing),
    .field_sel  (field_sel),
    .blank      (blank)
  );

  always #5 clk = ~clk;

  // ---- reference model state ----
  int          st = 0, age = 0;
  int          tD[1:3], oD[1:3];
  bit          mp, ip, accM, accI, accMPrev, accIPrev;
  bit          histM[$], histI[$];
  logic [23:0] expSet = '0;
  bit          expLoad, expEdit, expBlank;
  logic [1:0]  expFs;

  int          checks = 0, errors = 0;
  int          diverge = 0, dutLoads = 0, modelLoads = 0;
  logic [28:0] divGot, divWant;

  function automatic bit nextAcc(bit acc, bit hist[$]);
    if (!DEB) return hist[0];
    for (int k = 2; k <= D; k++) if (hist[k] != hist[1]) return acc;
    return hist[1];
  endfunction

  function automatic void incField(int f);
    int maxv, v;
    maxv = (f == 1) ? 23 : 59;
    v = tD[f] * 10 + oD[f];
    if (tD[f] > 9 || oD[f] > 9 || v >= maxv) v = 0;
    else v = v + 1;
    tD[f] = v / 10;
    oD[f] = v % 10;
  endfunction

  function automatic void modelEdge();
    bit nm, ni;
    if (rst) begin
      st = 0; age = 0;
      for (int f = 1; f <= 3; f++) begin tD[f] = 0; oD[f] = 0; end
      mp = 0; ip = 0; accM = 0; accI = 0; accMPrev = 0; accIPrev = 0;
      histM.delete(); histI.delete();
      for (int k = 0; k <= D; k++) begin histM.push_back(1'b0); histI.push_back(1'b0); end
    end else begin
      case (st)
        0: if (mp) begin
             tD[1] = int'(ct[23:20]); oD[1] = int'(ct[19:16]);
             tD[2] = int'(ct[15:12]); oD[2] = int'(ct[11:8]);
             tD[3] = int'(ct[7:4]);   oD[3] = int'(ct[3:0]);
             st = 1; age = 0;
           end
        1, 2, 3: if (mp) begin st++; age = 0; end
                 else if (ip) begin incField(st); age = 0; end
                 else age++;
        default: st = 0;
      endcase
      nm = accM & ~accMPrev;
      ni = accI & ~accIPrev;
      accMPrev = accM; accIPrev = accI;
      accM = nextAcc(accM, histM);
      accI = nextAcc(accI, histI);
      histM.push_front(bm); void'(histM.pop_back());
      histI.push_front(bi); void'(histI.pop_back());
      mp = nm; ip = ni;
    end
    expSet = 24'((tD[1] << 20) | (oD[1] << 16) | (tD[2] << 12) | (oD[2] << 8) | (tD[3] << 4) | oD[3]);
    expLoad  = (st == 4);
    expEdit  = (st >= 1 && st <= 3);
    expFs    = expEdit ? 2'(st) : 2'd0;
    expBlank = expEdit && ((age / B) % 2 == 1);
  endfunction

  // One clock: advance the model at the edge, observe the DUT at the negedge.
  task automatic step();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    if ({set_time, load, editing, field_sel, blank} !== {expSet, expLoad, expEdit, expFs, expBlank}) begin
      if (diverge == 0) begin
        divGot  = {set_time, load, editing, field_sel, blank};
        divWant = {expSet, expLoad, expEdit, expFs, expBlank};
      end
      diverge++;
    end
    if (load === 1'b1) dutLoads++;
    if (expLoad) modelLoads++;
  endtask

  task automatic press(input bit m, input bit i);
    bm = m; bi = i;
    repeat (LAT + 2) step();
    bm = 1'b0; bi = 1'b0;
    repeat (LAT + 3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (set_time !== 24'h0) begin errors++; $display("FAIL reset_set_time got %h want 000000", set_time); end
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load got %b want 0", load); end
    checks++; if (editing !== 1'b0) begin errors++; $display("FAIL reset_editing got %b want 0", editing); end
    checks++; if (field_sel !== 2'd0) begin errors++; $display("FAIL reset_field_sel got %0d want 0", field_sel); end
    checks++; if (blank !== 1'b0) begin errors++; $display("FAIL reset_blank got %b want 0", blank); end
    rst = 1'b0;
    step();
    diverge = 0;
  endtask

  task automatic test_full_edit();
    dutLoads = 0; modelLoads = 0; diverge = 0;
    ct = 24'h123456;
    press(1, 0);
    checks++; if (editing !== 1'b1) begin errors++; $display("FAIL edit_enter got %b want 1", editing); end
    checks++; if (field_sel !== 2'd1) begin errors++; $display("FAIL edit_fs_hr got %0d want 1", field_sel); end
    checks++; if (set_time !== 24'h123456) begin errors++; $display("FAIL edit_capture got %h want 123456", set_time); end
    press(0, 1); press(0, 1);
    checks++; if (set_time !== 24'h143456) begin errors++; $display("FAIL edit_hr_inc got %h want 143456", set_time); end
    press(1, 0);
    checks++; if (field_sel !== 2'd2) begin errors++; $display("FAIL edit_fs_min got %0d want 2", field_sel); end
    press(0, 1);
    press(1, 0);
    checks++; if (field_sel !== 2'd3) begin errors++; $display("FAIL edit_fs_sec got %0d want 3", field_sel); end
    press(1, 0);
    checks++; if (dutLoads !== 1) begin errors++; $display("FAIL edit_load_count got %0d want 1", dutLoads); end
    checks++; if (set_time !== 24'h143556) begin errors++; $display("FAIL edit_final got %h want 143556", set_time); end
    checks++; if (editing !== 1'b0 || field_sel !== 2'd0) begin errors++; $display("FAIL edit_exit got %b/%0d want 0/0", editing, field_sel); end
    checks++; if (diverge !== 0) begin errors++; $display("FAIL edit_model got %h want %h", divGot, divWant); end
  endtask

  task automatic test_wrap();
    diverge = 0;
    ct = 24'h235909;
    press(1, 0); press(0, 1);
    checks++; if (set_time !== 24'h005909) begin errors++; $display("FAIL wrap_hr got %h want 005909", set_time); end
    press(1, 0); press(1, 0); press(1, 0);
    ct = 24'h175909;
    press(1, 0); press(1, 0); press(0, 1);
    checks++; if (set_time !== 24'h170009) begin errors++; $display("FAIL wrap_min got %h want 170009", set_time); end
    press(1, 0); press(0, 1);
    checks++; if (set_time !== 24'h170010) begin errors++; $display("FAIL carry_sec got %h want 170010", set_time); end
    press(1, 0);
    ct = 24'h25637A;
    press(1, 0); press(0, 1);
    checks++; if (set_time !== 24'h00637A) begin errors++; $display("FAIL bad_hr got %h want 00637A", set_time); end
    press(1, 0); press(0, 1);
    press(1, 0); press(0, 1);
    checks++; if (set_time !== 24'h000000) begin errors++; $display("FAIL bad_min_sec got %h want 000000", set_time); end
    press(1, 0);
    checks++; if (diverge !== 0) begin errors++; $display("FAIL wrap_model got %h want %h", divGot, divWant); end
  endtask

  task automatic test_debounce();
    logic [23:0] prev;
    int changes, lastChg, wantChanges;
    logic [23:0] wantTime;
    diverge = 0; changes = 0; lastChg = -1;
    ct = 24'h000000;
    press(1, 0);
    prev = set_time;
    for (int k = 0; k < 50; k++) begin
      bi = (k >= 20) ? (k < 35) : ((k % 4) < 2);
      step();
      if (set_time !== prev) begin changes++; lastChg = k; prev = set_time; end
    end
    bi = 1'b0;
    wantChanges = DEB ? 1 : 6;
    wantTime    = DEB ? 24'h010000 : 24'h060000;
    checks++; if (changes !== wantChanges) begin errors++; $display("FAIL deb_count got %0d want %0d", changes, wantChanges); end
    checks++; if (lastChg !== 20 + LAT) begin errors++; $display("FAIL deb_latency got %0d want %0d", lastChg, 20 + LAT); end
    checks++; if (set_time !== wantTime) begin errors++; $display("FAIL deb_value got %h want %h", set_time, wantTime); end
    press(1, 0); press(1, 0); press(1, 0);
    checks++; if (diverge !== 0) begin errors++; $display("FAIL deb_model got %h want %h", divGot, divWant); end
  endtask

  task automatic test_simul_ignored();
    diverge = 0; dutLoads = 0;
    ct = 24'h080808;
    press(1, 0); press(1, 0);
    press(1, 1);
    checks++; if (field_sel !== 2'd3) begin errors++; $display("FAIL simul_state got %0d want 3", field_sel); end
    checks++; if (set_time !== 24'h080808) begin errors++; $display("FAIL simul_min got %h want 080808", set_time); end
    press(1, 0);
    checks++; if (dutLoads !== 1) begin errors++; $display("FAIL simul_load got %0d want 1", dutLoads); end
    dutLoads = 0;
    ct = 24'h111111;
    press(0, 1);
    checks++; if (set_time !== 24'h080808) begin errors++; $display("FAIL run_inc_time got %h want 080808", set_time); end
    checks++; if (dutLoads !== 0 || editing !== 1'b0) begin errors++; $display("FAIL run_inc_quiet got %0d/%b want 0/0", dutLoads, editing); end
    checks++; if (diverge !== 0) begin errors++; $display("FAIL simul_model got %h want %h", divGot, divWant); end
  endtask

  task automatic test_reset_mid();
    diverge = 0;
    ct = 24'h101010;
    press(1, 0); press(1, 0); press(0, 1); press(0, 1);
    checks++; if (set_time !== 24'h101210) begin errors++; $display("FAIL mid_pre got %h want 101210", set_time); end
    dutLoads = 0;
    rst = 1'b1;
    step();
    checks++; if (set_time !== 24'h0 || load !== 1'b0) begin errors++; $display("FAIL mid_time_load got %h/%b want 000000/0", set_time, load); end
    checks++; if (editing !== 1'b0 || field_sel !== 2'd0 || blank !== 1'b0) begin errors++; $display("FAIL mid_flags got %b/%0d/%b want 0/0/0", editing, field_sel, blank); end
    rst = 1'b0;
    repeat (12) step();
    checks++; if (dutLoads !== 0) begin errors++; $display("FAIL mid_no_load got %0d want 0", dutLoads); end
    checks++; if (diverge !== 0) begin errors++; $display("FAIL mid_model got %h want %h", divGot, divWant); end
  endtask

  task automatic test_blink();
    int e;
    bit bl[0:20];
    logic [7:0] hr[0:20];
    diverge = 0; e = -1;
    ct = 24'h050000;
    bm = 1'b1;
    for (int k = 0; k < 40 && e < 0; k++) begin
      step();
      if (field_sel === 2'd1) e = k;
    end
    bm = 1'b0;
    checks++; if (e < 0) begin errors++; $display("FAIL blink_entry got none want SET_HR"); end
    bl[0] = blank; hr[0] = set_time[23:16];
    for (int r = 1; r <= 20; r++) begin
      bi = (r >= 12 - LAT);
      step();
      bl[r] = blank; hr[r] = set_time[23:16];
    end
    bi = 1'b0;
    checks++; if (bl[0] !== 1'b0 || bl[7] !== 1'b0) begin errors++; $display("FAIL blink_low got %b%b want 00", bl[0], bl[7]); end
    checks++; if (bl[8] !== 1'b1 || bl[11] !== 1'b1) begin errors++; $display("FAIL blink_high got %b%b want 11", bl[8], bl[11]); end
    checks++; if (bl[12] !== 1'b0 || bl[19] !== 1'b0) begin errors++; $display("FAIL blink_restart got %b%b want 00", bl[12], bl[19]); end
    checks++; if (bl[20] !== 1'b1) begin errors++; $display("FAIL blink_retoggle got %b want 1", bl[20]); end
    checks++; if (hr[11] !== 8'h05 || hr[12] !== 8'h06) begin errors++; $display("FAIL blink_inc got %h/%h want 05/06", hr[11], hr[12]); end
    press(1, 0); press(1, 0); press(1, 0);
    checks++; if (diverge !== 0) begin errors++; $display("FAIL blink_model got %h want %h", divGot, divWant); end
  endtask

  task automatic test_random();
    int h, m, s, n;
    for (int it = 0; it < 12; it++) begin
      diverge = 0; dutLoads = 0; modelLoads = 0;
      if ($urandom_range(0, 1) == 1) begin
        h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
        ct = 24'(((h / 10) << 20) | ((h % 10) << 16) | ((m / 10) << 12) | ((m % 10) << 8) | ((s / 10) << 4) | (s % 10));
      end else begin
        ct = 24'($urandom);
      end
      for (int f = 0; f < 4; f++) begin
        press(1, $urandom_range(0, 3) == 0);
        if (f < 3) begin
          n = $urandom_range(0, 3);
          for (int j = 0; j < n; j++) press(0, 1);
        end
      end
      checks++; if (set_time !== expSet) begin errors++; $display("FAIL rand_time[%0d] got %h want %h", it, set_time, expSet); end
      checks++; if (dutLoads !== 1 || modelLoads !== 1 || diverge !== 0) begin errors++; $display("FAIL rand_seq[%0d] got loads %0d div %0d (%h) want loads 1 div 0 (%h)", it, dutLoads, diverge, divGot, divWant); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_edit();
    test_wrap();
    test_debounce();
    test_simul_ignored();
    test_reset_mid();
    test_blink();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
